ray_setup_recip: RTL and testbench

Ray-setup stage directly upstream of the ray/box slab tester. It accepts a ray (Q16.16 origin and direction), computes the Q16.16 reciprocal direction for each axis with one shared iterative restoring divider, and presents origin plus reciprocal direction to the slab stage over a valid/ready handshake. Division by zero and overflow saturate so that axis-parallel rays produce very large, correctly signed slab distances.

---
 rtl/ray_setup_recip.sv | 154 +++++++++++++++
 tb/tb_ray_setup_recip.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ray_setup_recip.sv
// Ray-setup stage: registers a ray and computes the Q16.16 reciprocal of each
// direction component with one shared restoring divider (2^32 / |d|), saturating.
module ray_setup_recip #(
  parameter logic [31:0] ZERO_EPS = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] ox,
  input  logic signed [31:0] oy,
  input  logic signed [31:0] oz,
  input  logic signed [31:0] dx,
  input  logic signed [31:0] dy,
  input  logic signed [31:0] dz,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] ox_o,
  output logic signed [31:0] oy_o,
  output logic signed [31:0] oz_o,
  output logic signed [31:0] invdx,
  output logic signed [31:0] invdy,
  output logic signed [31:0] invdz,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid, once high, holds its payload stable until that edge.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         axis_q;
  logic [5:0]         step_q;
  logic [32:0]        rem_q;
  logic [31:0]        quo_q;
  logic signed [31:0] dx_q, dy_q, dz_q;

  logic [31:0] d_cur;
  logic [31:0] mag_d;
  logic [33:0] rem_sh;
  logic [32:0] rem_sub;
  logic        take;
  logic [32:0] rem_next;
  logic [32:0] quo_next;
  logic        sat;
  logic [31:0] mag;
  logic [31:0] result;
  logic        last_step;

  assign dbg_state = state_q;

  // One restoring-division step for the current axis; dividend is 1 then 32 zeros.
  always_comb begin
    case (axis_q)
      2'd0:    d_cur = dx_q;
      2'd1:    d_cur = dy_q;
      default: d_cur = dz_q;
    endcase
    mag_d     = d_cur[31] ? (~d_cur + 32'd1) : d_cur;
    rem_sh    = {rem_q, (step_q == 6'd0)};
    take      = (rem_sh >= {2'b00, mag_d});
    rem_sub   = rem_sh[32:0] - {1'b0, mag_d};
    rem_next  = take ? rem_sub : rem_sh[32:0];
    quo_next  = {quo_q, take};
    sat       = (mag_d <= ZERO_EPS) || (quo_next > 33'h0_7FFF_FFFF);
    mag       = sat ? 32'h7FFF_FFFF : quo_next[31:0];
    result    = d_cur[31] ? (~mag + 32'd1) : mag;
    last_step = (step_q == 6'd32);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_DIV;
      S_DIV:   if (last_step && axis_q == 2'd2) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      axis_q    <= 2'd0;
      step_q    <= 6'd0;
      rem_q     <= '0;
      quo_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      dz_q      <= '0;
      ox_o      <= '0;
      oy_o      <= '0;
      oz_o      <= '0;
      invdx     <= '0;
      invdy     <= '0;
      invdz     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ox_o     <= ox;
            oy_o     <= oy;
            oz_o     <= oz;
            dx_q     <= dx;
            dy_q     <= dy;
            dz_q     <= dz;
            rem_q    <= '0;
            quo_q    <= '0;
            axis_q   <= 2'd0;
            step_q   <= 6'd0;
            in_ready <= 1'b0;
          end
        end
        S_DIV: begin
          if (last_step) begin
            case (axis_q)
              2'd0:    invdx <= result;
              2'd1:    invdy <= result;
              default: invdz <= result;
            endcase
            rem_q  <= '0;
            quo_q  <= '0;
            step_q <= 6'd0;
            if (axis_q == 2'd2) begin
              axis_q    <= 2'd0;
              out_valid <= 1'b1;
            end else begin
              axis_q <= axis_q + 2'd1;
            end
          end else begin
            rem_q  <= rem_next;
            quo_q  <= quo_next[31:0];
            step_q <= step_q + 6'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_setup_recip.sv
// Directed + randomized bench for ray_setup_recip; two instances (ZERO_EPS 0 and 4)
// run in lockstep and are checked against an arithmetic reciprocal model.
module tb_ray_setup_recip;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] ox = '0, oy = '0, oz = '0, dx = '0, dy = '0, dz = '0;

  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [31:0] ox_o, oy_o, oz_o, invdx, invdy, invdz;
  logic [31:0] ox_o4, oy_o4, oz_o4, invdx4, invdy4, invdz4;
  logic [1:0]  dbg_state, dbg_state4;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle = 0;
  logic [31:0] exp_q[$];

  ray_setup_recip #(.ZERO_EPS(32'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
    .out_valid(out_valid), .out_ready(out_ready),
    .ox_o(ox_o), .oy_o(oy_o), .oz_o(oz_o),
    .invdx(invdx), .invdy(invdy), .invdz(invdz), .dbg_state(dbg_state)
  );

  ray_setup_recip #(.ZERO_EPS(32'd4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
    .out_valid(out_valid4), .out_ready(out_ready),
    .ox_o(ox_o4), .oy_o(oy_o4), .oz_o(oz_o4),
    .invdx(invdx4), .invdy(invdy4), .invdz(invdz4), .dbg_state(dbg_state4)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // reciprocal model: 2^32 / |d| with saturation, sign restored
  function automatic logic [31:0] ref_recip(input logic [31:0] d, input longint unsigned eps);
    longint unsigned m, q, mag;
    m = d[31] ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
    if (m <= eps) mag = 64'h7FFF_FFFF;
    else begin
      q   = 64'h1_0000_0000 / m;
      mag = (q > 64'h7FFF_FFFF) ? 64'h7FFF_FFFF : q;
    end
    return d[31] ? (~mag[31:0] + 32'd1) : mag[31:0];
  endfunction

  function automatic logic [31:0] rand_dir();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) v = $urandom();
    else begin
      v = $urandom_range(0, 32'h0004_0000);
      if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_outputs(input logic [31:0] e[9], input string ph);
    chk({ph, "_ox"}, ox_o, e[0]);
    chk({ph, "_oy"}, oy_o, e[1]);
    chk({ph, "_oz"}, oz_o, e[2]);
    chk({ph, "_invdx"}, invdx, e[3]);
    chk({ph, "_invdy"}, invdy, e[4]);
    chk({ph, "_invdz"}, invdz, e[5]);
    chk({ph, "_invdx_eps4"}, invdx4, e[6]);
    chk({ph, "_invdy_eps4"}, invdy4, e[7]);
    chk({ph, "_invdz_eps4"}, invdz4, e[8]);
    chk({ph, "_out_valid_eps4"}, 32'(out_valid4), 32'd1);
  endtask

  // driver: one ray; hold > 0 keeps out_ready low that many cycles after out_valid
  task automatic run_ray(input logic [31:0] a_ox, a_oy, a_oz, a_dx, a_dy, a_dz,
                         input int hold, output int t_out);
    logic [31:0] e[9];
    int lat;
    exp_q.push_back(a_ox); exp_q.push_back(a_oy); exp_q.push_back(a_oz);
    exp_q.push_back(ref_recip(a_dx, 0)); exp_q.push_back(ref_recip(a_dy, 0));
    exp_q.push_back(ref_recip(a_dz, 0));
    exp_q.push_back(ref_recip(a_dx, 4)); exp_q.push_back(ref_recip(a_dy, 4));
    exp_q.push_back(ref_recip(a_dz, 4));
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    ox = a_ox; oy = a_oy; oz = a_oz; dx = a_dx; dy = a_dy; dz = a_dz;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ox = $urandom(); oy = $urandom(); oz = $urandom();
    dx = $urandom(); dy = $urandom(); dz = $urandom();
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd99);
    t_out = cycle;
    for (int i = 0; i < 9; i++) e[i] = exp_q.pop_front();
    check_outputs(e, "result");
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        ox = $urandom(); dx = $urandom(); dy = $urandom(); dz = $urandom();
        tick();
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        check_outputs(e, "bp");
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  // scoreboard run
  initial begin
    int t0, t1, t_prev, seen;
    logic [31:0] d3[3];

    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_ox", ox_o, 32'd0);
    chk("rst_invdx", invdx, 32'd0);
    chk("rst_invdz", invdz, 32'd0);
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    run_ray(32'h0005_0000, 32'hFFFB_0000, 32'h0, 32'h0001_0000, 32'h0002_0000,
            32'h0003_0000, 0, t0);
    chk("basic_invdx", invdx, 32'h0001_0000);
    chk("basic_invdy", invdy, 32'h0000_8000);
    chk("basic_invdz", invdz, 32'h0000_5555);
    chk("basic_oy", oy_o, 32'hFFFB_0000);

    run_ray($urandom(), $urandom(), $urandom(), 32'hFFFF_8000, 32'hFFFF_0000,
            32'h8000_0000, 0, t0);
    chk("neg_invdx", invdx, 32'hFFFE_0000);
    chk("neg_invdy", invdy, 32'hFFFF_0000);
    chk("neg_invdz", invdz, 32'hFFFF_FFFE);

    run_ray($urandom(), $urandom(), $urandom(), 32'h0, 32'h1, 32'hFFFF_FFFF, 0, t0);
    chk("sat_invdx", invdx, 32'h7FFF_FFFF);
    chk("sat_invdy", invdy, 32'h7FFF_FFFF);
    chk("sat_invdz", invdz, 32'h8000_0001);

    run_ray($urandom(), $urandom(), $urandom(), 32'd3, 32'hFFFF_FFFD, 32'd4, 0, t0);
    chk("eps4_pos", invdx4, 32'h7FFF_FFFF);
    chk("eps4_neg", invdy4, 32'h8000_0001);
    chk("eps4_edge", invdz4, 32'h7FFF_FFFF);
    chk("eps0_edge", invdz, 32'h4000_0000);

    run_ray(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'd5, rand_dir(),
            rand_dir(), 20, t0);
    chk("bp_eps4_five", invdx4, 32'h3333_3333);
    tick();
    chk("bp_no_second_accept", 32'(in_ready), 32'd1);

    for (int i = 0; i < 4; i++)
      run_ray($urandom(), $urandom(), $urandom(), rand_dir(), rand_dir(), rand_dir(),
              $urandom_range(0, 3), t0);

    // streaming: out_ready held high, next ray offered as soon as in_ready returns
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) d3[k] = rand_dir();
      run_ray($urandom(), $urandom(), $urandom(), d3[0], d3[1], d3[2], 0, t1);
      if (i > 0) chk("stream_spacing", 32'(t1 - t_prev), 32'd101);
      t_prev = t1;
    end

    // mid-DIV abort
    ox = 32'h0000_1111; dx = 32'h0001_0000; dy = 32'h0002_0000; dz = 32'h0003_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (40) tick();
    chk("abort_state_div", 32'(dbg_state), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_ox", ox_o, 32'd0);
    chk("abort_invdx", invdx, 32'd0);
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
